// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Direction and mode encodings plus the prescaler divider width function.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  // A single-cycle prescaler still gets a 1-bit divider; it is held at zero.
  function automatic int prescale_w(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: tick is high on the PRESCALE-th advance; clear restarts the count.
// Latency: tick is combinational from the divider register; no backpressure.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = prescale_w(PRESCALE);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign tick = (div_q == LAST);

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (advance) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with load, prescaler and wrap/saturate limits; count, wrap_p registered, 1-cycle latency.
// Optional compare pulse under PARAM_COUNTER_MATCH_EN; no backpressure, ena=0 freezes all state.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             wrap_p,
  output logic             oe
`ifdef PARAM_COUNTER_MATCH_EN
  ,
  input  logic [WIDTH-1:0] cmp_val,
  output logic             match_p
`endif
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be 2..16");
  end
  if (MAX_VAL < 1 || MAX_VAL >= (1 << WIDTH)) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL must be below 2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE must be 1..256");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             is_max, is_zero;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (ena & cnt_en & ~load),
    .clear   (ena & load),
    .tick    (tick)
  );

  assign is_max   = (count_q == MAX_C);
  assign is_zero  = (count_q == '0);
  assign at_limit = (up_dn == DIR_UP) ? is_max : is_zero;
  assign count    = count_q;
  assign wrap_p   = wrap_q;
  assign oe       = ena & ~is_max;

  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (ena) begin
      wrap_d = 1'b0;
      if (load) begin
        count_d = (load_val > MAX_C) ? MAX_C : load_val;
      end else if (cnt_en && tick) begin
        wrap_d = at_limit;
        if (at_limit) begin
          if (SATURATE == MODE_SAT) begin
            count_d = count_q;
          end else begin
            count_d = (up_dn == DIR_UP) ? '0 : MAX_C;
          end
        end else begin
          count_d = (up_dn == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef PARAM_COUNTER_MATCH_EN
  logic match_q, match_d;

  // Only a change of count onto cmp_val pulses; sitting at the value does not.
  always_comb begin
    match_d = match_q;
    if (ena) begin
      match_d = (count_d != count_q) && (count_d == cmp_val);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match_p = match_q;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter across four parameter sets.
// Build with PARAM_COUNTER_MATCH_EN defined to also exercise the compare pulse.
module tb_param_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // a: free-running 8-bit wrap counter
  logic a_rst_n, a_ena, a_cnt_en, a_up, a_load, a_lim, a_wrap, a_oe, a_match;
  logic [7:0] a_lv, a_count, a_cmp;
  // b: 8-bit saturating
  logic b_rst_n, b_ena, b_cnt_en, b_up, b_load, b_lim, b_wrap, b_oe, b_match;
  logic [7:0] b_lv, b_count, b_cmp;
  // c: 4-bit, MAX_VAL 9, PRESCALE 4
  logic c_rst_n, c_ena, c_cnt_en, c_up, c_load, c_lim, c_wrap, c_oe, c_match;
  logic [3:0] c_lv, c_count, c_cmp;
  // d: 8-bit, MAX_VAL 99, PRESCALE 4
  logic d_rst_n, d_ena, d_cnt_en, d_up, d_load, d_lim, d_wrap, d_oe, d_match;
  logic [7:0] d_lv, d_count, d_cmp;

  param_updown_counter #(.WIDTH(8)) u_a (
`ifdef PARAM_COUNTER_MATCH_EN
    .cmp_val(a_cmp), .match_p(a_match),
`endif
    .clk(clk), .rst_n(a_rst_n), .ena(a_ena), .cnt_en(a_cnt_en), .up_dn(a_up),
    .load(a_load), .load_val(a_lv), .count(a_count), .at_limit(a_lim),
    .wrap_p(a_wrap), .oe(a_oe)
  );

  param_updown_counter #(.WIDTH(8), .SATURATE(1)) u_b (
`ifdef PARAM_COUNTER_MATCH_EN
    .cmp_val(b_cmp), .match_p(b_match),
`endif
    .clk(clk), .rst_n(b_rst_n), .ena(b_ena), .cnt_en(b_cnt_en), .up_dn(b_up),
    .load(b_load), .load_val(b_lv), .count(b_count), .at_limit(b_lim),
    .wrap_p(b_wrap), .oe(b_oe)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4)) u_c (
`ifdef PARAM_COUNTER_MATCH_EN
    .cmp_val(c_cmp), .match_p(c_match),
`endif
    .clk(clk), .rst_n(c_rst_n), .ena(c_ena), .cnt_en(c_cnt_en), .up_dn(c_up),
    .load(c_load), .load_val(c_lv), .count(c_count), .at_limit(c_lim),
    .wrap_p(c_wrap), .oe(c_oe)
  );

  param_updown_counter #(.WIDTH(8), .MAX_VAL(99), .PRESCALE(4)) u_d (
`ifdef PARAM_COUNTER_MATCH_EN
    .cmp_val(d_cmp), .match_p(d_match),
`endif
    .clk(clk), .rst_n(d_rst_n), .ena(d_ena), .cnt_en(d_cnt_en), .up_dn(d_up),
    .load(d_load), .load_val(d_lv), .count(d_count), .at_limit(d_lim),
    .wrap_p(d_wrap), .oe(d_oe)
  );

  initial begin
    int exp_b [6];
    int e;
    exp_b = '{2, 1, 0, 0, 0, 0};

    a_rst_n = 0; a_ena = 1; a_cnt_en = 1; a_up = 1; a_load = 1; a_lv = 8'd77; a_cmp = 8'd5;
    b_rst_n = 0; b_ena = 1; b_cnt_en = 0; b_up = 1; b_load = 0; b_lv = 8'd0;  b_cmp = 8'd0;
    c_rst_n = 0; c_ena = 1; c_cnt_en = 0; c_up = 1; c_load = 0; c_lv = 4'd0;  c_cmp = 4'd0;
    d_rst_n = 0; d_ena = 1; d_cnt_en = 0; d_up = 1; d_load = 0; d_lv = 8'd0;  d_cmp = 8'd0;

    cyc();
    cyc();
    check("rst_a_count", 32'(a_count), 0);
    check("rst_a_wrap", 32'(a_wrap), 0);
    check("rst_a_oe", 32'(a_oe), 1);
    check("rst_c_count", 32'(c_count), 0);
    check("rst_d_count", 32'(d_count), 0);
`ifdef PARAM_COUNTER_MATCH_EN
    check("rst_a_match", 32'(a_match), 0);
`endif

    a_load = 0;
    a_rst_n = 1; b_rst_n = 1; c_rst_n = 1; d_rst_n = 1;

    // free-run through a full wrap
    for (int k = 1; k <= 256; k++) begin
      cyc();
      e = k % 256;
      check("a_count", 32'(a_count), 32'(e));
      check("a_wrap", 32'(a_wrap), (k == 256) ? 1 : 0);
      check("a_oe", 32'(a_oe), (e != 255) ? 1 : 0);
      check("a_at_limit", 32'(a_lim), (e == 255) ? 1 : 0);
`ifdef PARAM_COUNTER_MATCH_EN
      check("a_match_run", 32'(a_match), (e == 5) ? 1 : 0);
`endif
    end

`ifdef PARAM_COUNTER_MATCH_EN
    a_cnt_en = 0; a_load = 1; a_lv = 8'd5;
    cyc();
    check("a_match_load", 32'(a_match), 1);
    check("a_match_load_cnt", 32'(a_count), 5);
    a_load = 0;
    cyc();
    check("a_match_hold1", 32'(a_match), 0);
    cyc();
    check("a_match_hold2", 32'(a_match), 0);
`endif

    // saturating count-down
    b_load = 1; b_lv = 8'd3;
    cyc();
    check("b_load3", 32'(b_count), 3);
    b_load = 0; b_up = 0; b_cnt_en = 1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("b_down_count", 32'(b_count), 32'(exp_b[k-1]));
      check("b_down_wrap", 32'(b_wrap), (k >= 4) ? 1 : 0);
    end
    check("b_at_limit_zero", 32'(b_lim), 1);
    b_cnt_en = 0; b_up = 1; b_load = 1; b_lv = 8'd255;
    cyc();
    check("b_load255_wrap", 32'(b_wrap), 0);
    b_load = 0; b_cnt_en = 1;
    cyc();
    check("b_sat_up_count", 32'(b_count), 255);
    check("b_sat_up_wrap", 32'(b_wrap), 1);
    check("b_sat_oe", 32'(b_oe), 0);
    b_cnt_en = 0;
    cyc();
    check("b_idle_wrap", 32'(b_wrap), 0);

    // prescale by 4, modulo 10
    c_cnt_en = 1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      e = (k / 4) % 10;
      check("c_count", 32'(c_count), 32'(e));
      check("c_wrap", 32'(c_wrap), (k == 40) ? 1 : 0);
      check("c_oe", 32'(c_oe), (e != 9) ? 1 : 0);
    end
    cyc();
    cyc();
    check("c_partial", 32'(c_count), 0);
    c_cnt_en = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("c_frozen", 32'(c_count), 0);
    end
    c_cnt_en = 1;
    cyc();
    check("c_resume_pre", 32'(c_count), 0);
    cyc();
    check("c_resume_step", 32'(c_count), 1);
    c_cnt_en = 0;

    // load clamps and clears the divider
    d_cnt_en = 1;
    cyc();
    cyc();
    check("d_pre_load", 32'(d_count), 0);
    d_load = 1; d_lv = 8'd200;
    cyc();
    check("d_clamp", 32'(d_count), 99);
    check("d_clamp_oe", 32'(d_oe), 0);
    check("d_clamp_lim", 32'(d_lim), 1);
    check("d_clamp_wrap", 32'(d_wrap), 0);
    d_load = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("d_div_cleared", 32'(d_count), 99);
    end
    cyc();
    check("d_wrap_count", 32'(d_count), 0);
    check("d_wrap_pulse", 32'(d_wrap), 1);
    cyc();
    cyc();
    cyc();
    check("d_before_tick", 32'(d_count), 0);
    d_load = 1; d_lv = 8'd42;
    cyc();
    check("d_load_wins", 32'(d_count), 42);
    check("d_load_wins_wrap", 32'(d_wrap), 0);

    // ena low freezes even a load; reset beats load
    d_cnt_en = 0; d_ena = 0; d_lv = 8'd7;
    cyc();
    check("d_ena0_hold", 32'(d_count), 42);
    check("d_ena0_oe", 32'(d_oe), 0);
    d_ena = 1; d_lv = 8'd50;
    cyc();
    check("d_load50", 32'(d_count), 50);
    d_rst_n = 0;
    cyc();
    check("d_rst_over_load", 32'(d_count), 0);
    check("d_rst_wrap", 32'(d_wrap), 0);
    d_rst_n = 1; d_load = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
